// File: rtl/axis_cpu_imem.sv
// Instruction memory for axis_cpu: CPU fetch port plus a command-stream programming port
// that writes, reads back and controls the CPU hold-in-reset line.
module axis_cpu_imem #(
  parameter int CODE_ADDR_WIDTH = 10,
  parameter int CODE_DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CODE_ADDR_WIDTH-1:0] inst_rd_addr,
  input  logic                       inst_rd_en,
  output logic [CODE_DATA_WIDTH-1:0] instr_out,
  input  logic [31:0]                cmd_in_TDATA,
  input  logic                       cmd_in_TVALID,
  output logic [31:0]                cmd_out_TDATA,
  output logic                       cmd_out_TVALID,
  output logic                       hold_in_rst,
  output logic                       cmd_overrun
);

  // state | meaning
  // IDLE  | waiting for a header word
  // WRITE | storing data beats at addr, cnt beats remaining
  // ACK   | write acknowledge visible on cmd_out, CPU still held
  // READ  | one memory read per cycle, cnt reads remaining
  typedef enum logic [1:0] {IDLE, WRITE, ACK, READ} state_t;

  localparam int AW = CODE_ADDR_WIDTH;
  localparam int DW = CODE_DATA_WIDTH;

  logic [DW-1:0] mem [2**AW];

  state_t        state, state_nxt;
  logic [AW-1:0] addr, addr_nxt, addr_inc;
  logic [12:0]   cnt, cnt_nxt;
  logic [11:0]   cnt_hdr, cnt_hdr_nxt;
  logic          hold_reg, hold_nxt;
  logic          out_vld_nxt, out_rd, ovr_nxt, mem_we;
  logic [31:0]   out_word_nxt;

  logic [3:0]    hdr_op;
  logic [11:0]   hdr_cnt;
  logic [AW-1:0] hdr_addr;
  logic          unused_hdr_bits;

  assign hdr_op          = cmd_in_TDATA[31:28];
  assign hdr_cnt         = cmd_in_TDATA[27:16];
  assign hdr_addr        = cmd_in_TDATA[AW-1:0];
  assign unused_hdr_bits = ^cmd_in_TDATA[15:0];
  assign addr_inc        = addr + AW'(1);

  function automatic logic [15:0] zext_addr(input logic [AW-1:0] a);
    logic [15:0] r;
    r = '0;
    r[AW-1:0] = a;
    return r;
  endfunction

  function automatic logic [31:0] zext_data(input logic [DW-1:0] d);
    logic [31:0] r;
    r = '0;
    r[DW-1:0] = d;
    return r;
  endfunction

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    cnt_nxt      = cnt;
    cnt_hdr_nxt  = cnt_hdr;
    hold_nxt     = hold_reg;
    out_vld_nxt  = 1'b0;
    out_word_nxt = '0;
    out_rd       = 1'b0;
    ovr_nxt      = 1'b0;
    mem_we       = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_in_TVALID) begin
          case (hdr_op)
            4'd0: ;
            4'd1, 4'd2: begin
              state_nxt   = (hdr_op == 4'd1) ? WRITE : READ;
              addr_nxt    = hdr_addr;
              cnt_nxt     = {1'b0, hdr_cnt} + 13'd1;
              cnt_hdr_nxt = hdr_cnt;
            end
            4'd3: begin
              hold_nxt     = cmd_in_TDATA[0];
              out_vld_nxt  = 1'b1;
              out_word_nxt = {4'hA, hdr_cnt, zext_addr(hdr_addr)};
            end
            default: begin
              out_vld_nxt  = 1'b1;
              out_word_nxt = {4'hE, 28'h0};
            end
          endcase
        end
      end
      WRITE: begin
        if (cmd_in_TVALID) begin
          mem_we   = 1'b1;
          addr_nxt = addr_inc;
          cnt_nxt  = cnt - 13'd1;
          // ack is registered here so it is visible during the ACK cycle itself
          if (cnt == 13'd1) begin
            state_nxt    = ACK;
            out_vld_nxt  = 1'b1;
            out_word_nxt = {4'hA, cnt_hdr, zext_addr(addr_inc)};
          end
        end
      end
      ACK: begin
        state_nxt = IDLE;
        ovr_nxt   = cmd_in_TVALID;
      end
      READ: begin
        out_vld_nxt = 1'b1;
        out_rd      = 1'b1;
        addr_nxt    = addr_inc;
        cnt_nxt     = cnt - 13'd1;
        ovr_nxt     = cmd_in_TVALID;
        if (cnt == 13'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr           <= '0;
      cnt            <= '0;
      cnt_hdr        <= '0;
      hold_reg       <= 1'b1;
      cmd_out_TDATA  <= '0;
      cmd_out_TVALID <= 1'b0;
      cmd_overrun    <= 1'b0;
    end else begin
      state          <= state_nxt;
      addr           <= addr_nxt;
      cnt            <= cnt_nxt;
      cnt_hdr        <= cnt_hdr_nxt;
      hold_reg       <= hold_nxt;
      cmd_out_TVALID <= out_vld_nxt;
      cmd_overrun    <= ovr_nxt;
      if (out_rd)
        cmd_out_TDATA <= zext_data(mem[addr]);
      else if (out_vld_nxt)
        cmd_out_TDATA <= out_word_nxt;
    end
  end

  // Memory is not reset; both read ports see pre-write data (read-first)
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= cmd_in_TDATA[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          instr_out <= '0;
    else if (inst_rd_en) instr_out <= mem[inst_rd_addr];
  end

  assign hold_in_rst = hold_reg | (state == WRITE) | (state == ACK);

endmodule

// File: tb/tb_axis_cpu_imem.sv
// Directed bench for axis_cpu_imem: cmd_out words are checked against a scoreboard queue
// filled as commands are driven; other outputs are checked inline.
module tb_axis_cpu_imem;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  inst_rd_addr = '0;
  logic        inst_rd_en = 1'b0;
  logic [7:0]  instr_out;
  logic [31:0] cmd_in_TDATA = '0;
  logic        cmd_in_TVALID = 1'b0;
  logic [31:0] cmd_out_TDATA;
  logic        cmd_out_TVALID;
  logic        hold_in_rst;
  logic        cmd_overrun;

  int passed = 0;
  int total = 0;
  int cycle = 0;
  int ovr_cnt = 0;
  logic [31:0] exp_q[$];
  int          ts_q[$];

  axis_cpu_imem #(.CODE_ADDR_WIDTH(10), .CODE_DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_rd_addr(inst_rd_addr), .inst_rd_en(inst_rd_en), .instr_out(instr_out),
    .cmd_in_TDATA(cmd_in_TDATA), .cmd_in_TVALID(cmd_in_TVALID),
    .cmd_out_TDATA(cmd_out_TDATA), .cmd_out_TVALID(cmd_out_TVALID),
    .hold_in_rst(hold_in_rst), .cmd_overrun(cmd_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Scoreboard consumer: every cmd_out word must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && cmd_overrun) ovr_cnt++;
    if (rst_n && cmd_out_TVALID) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cmd_out", {31'd0, cmd_out_TVALID}, 32'd0);
      end else begin
        check("cmd_out", cmd_out_TDATA, exp_q.pop_front());
        ts_q.push_back(cycle);
      end
    end
  end

  task automatic send(input logic [31:0] w);
    @(posedge clk); #1;
    cmd_in_TDATA  = w;
    cmd_in_TVALID = 1'b1;
  endtask

  task automatic idle_in();
    @(posedge clk); #1;
    cmd_in_TVALID = 1'b0;
    cmd_in_TDATA  = '0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_hold", {31'd0, hold_in_rst}, 32'd1);
    check("rst_valid", {31'd0, cmd_out_TVALID}, 32'd0);
    check("rst_instr", {24'd0, instr_out}, 32'd0);
    check("rst_overrun", {31'd0, cmd_overrun}, 32'd0);

    // write 3 words at 5, hold asserted throughout
    exp_q.push_back(32'hA002_0008);
    send(32'h1002_0005);
    @(negedge clk); check("wr_hold_hdr", {31'd0, hold_in_rst}, 32'd1);
    send(32'h11); @(negedge clk); check("wr_hold_d0", {31'd0, hold_in_rst}, 32'd1);
    send(32'h22); @(negedge clk); check("wr_hold_d1", {31'd0, hold_in_rst}, 32'd1);
    send(32'h33); @(negedge clk); check("wr_hold_d2", {31'd0, hold_in_rst}, 32'd1);
    idle_in(); @(negedge clk); check("wr_hold_ack", {31'd0, hold_in_rst}, 32'd1);
    wait_drain("wr_ack_drain");

    exp_q.push_back(32'h11); exp_q.push_back(32'h22); exp_q.push_back(32'h33);
    send(32'h2002_0005); idle_in();
    wait_drain("rd_5_drain");

    // wrap-around write and read
    exp_q.push_back(32'hA001_0001);
    send(32'h1001_03FF); send(32'hA5); send(32'h5A); idle_in();
    wait_drain("wrap_wr_drain");
    ts_q.delete();
    exp_q.push_back(32'hA5); exp_q.push_back(32'h5A);
    send(32'h2001_03FF); idle_in();
    wait_drain("wrap_rd_drain");
    check("wrap_rd_count", ts_q.size(), 2);
    if (ts_q.size() == 2) check("wrap_rd_consecutive", ts_q[1] - ts_q[0], 1);

    // release CPU and fetch
    exp_q.push_back(32'hA000_0000);
    send(32'h3000_0000); idle_in();
    wait_drain("hold_drain");
    check("hold_released", {31'd0, hold_in_rst}, 32'd0);
    @(posedge clk); #1 inst_rd_en = 1'b1; inst_rd_addr = 10'd6;
    @(posedge clk); #1 inst_rd_en = 1'b0; inst_rd_addr = 10'd5;
    @(negedge clk); check("fetch_6", {24'd0, instr_out}, 32'h22);
    @(posedge clk); @(negedge clk); check("fetch_hold", {24'd0, instr_out}, 32'h22);
    @(posedge clk); #1 inst_rd_en = 1'b1; inst_rd_addr = 10'd0;
    @(posedge clk); #1 inst_rd_en = 1'b0;
    @(negedge clk); check("fetch_0", {24'd0, instr_out}, 32'h5A);

    // bad opcode and NOP
    exp_q.push_back(32'hE000_0000);
    send(32'h7000_0000); send(32'h0000_0000); idle_in();
    wait_drain("err_drain");

    // overrun during a 4-word read
    exp_q.push_back(32'hA003_0014);
    send(32'h1003_0010); send(32'h01); send(32'h02); send(32'h03); send(32'h04); idle_in();
    wait_drain("wr4_drain");
    check("ovr_none_yet", ovr_cnt, 0);
    exp_q.push_back(32'h01); exp_q.push_back(32'h02); exp_q.push_back(32'h03); exp_q.push_back(32'h04);
    send(32'h2003_0010); send(32'h1000_00FF); idle_in();
    wait_drain("ovr_rd_drain");
    check("ovr_pulse_count", ovr_cnt, 1);
    exp_q.push_back(32'h01); exp_q.push_back(32'h02); exp_q.push_back(32'h03); exp_q.push_back(32'h04);
    send(32'h2003_0010); idle_in();
    wait_drain("ovr_mem_unchanged");

    // abort a write with reset after the first data beat
    send(32'h1002_0020); send(32'h77); idle_in();
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_hold", {31'd0, hold_in_rst}, 32'd1);
    check("abort_valid", {31'd0, cmd_out_TVALID}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_hold_after", {31'd0, hold_in_rst}, 32'd1);
    exp_q.push_back(32'h77);
    send(32'h2000_0020); idle_in();
    wait_drain("abort_retained");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
